// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare predictor: FSM states, PHT indexing
// and saturating counter arithmetic.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Raw gshare hash; callers truncate to the PHT index width.
  function automatic logic [31:0] pht_idx(input logic [31:0] pc, input logic [31:0] ghr);
    return (pc >> 2) ^ ghr;
  endfunction

  // Saturating counter step between 0 and ctr_max.
  function automatic logic [31:0] ctr_next(input logic [31:0] ctr, input logic taken,
                                           input logic [31:0] ctr_max);
    if (taken) return (ctr == ctr_max) ? ctr : ctr + 32'd1;
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/bp_ckpt_queue.sv
// Circular FIFO of GHR snapshots, one per in-flight branch. Pointers carry an
// extra wrap bit so full and empty are distinguishable.
module bp_ckpt_queue #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  input  logic            clear,
  output logic [W-1:0]    head_data,
  output logic [ID_W-1:0] head_id,
  output logic [ID_W-1:0] tail_id,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PW = ID_W + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_next;

  assign head_next = head + PW'(pop);
  assign head_data = mem[head[ID_W-1:0]];
  assign head_id   = head[ID_W-1:0];
  assign tail_id   = tail[ID_W-1:0];
  assign empty     = (head == tail);
  assign full      = (head[ID_W-1:0] == tail[ID_W-1:0]) && (head[ID_W] != tail[ID_W]);

  // Clearing drops everything younger than the popped head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_next;
      if (clear)             tail <= head_next;
      else if (push && !full) tail <= tail + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clear && !rst) mem[tail[ID_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/gshare_predictor_ckpt.sv
// Gshare direction predictor with per-branch GHR checkpoints for exact history
// restore on mispredict, a post-reset PHT init sweep and a committed GHR for flush.
module gshare_predictor_ckpt
  import bp_pkg::*;
#(
  parameter int unsigned GHR_LEN    = 8,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned CTR_W      = 2,
  parameter int unsigned CKPT_DEPTH = 4,
  parameter int unsigned ID_W       = $clog2(CKPT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [31:0]     pc_f,
  output logic            pred_taken_f,
  input  logic            spec_valid,
  input  logic            spec_taken,
  output logic [ID_W-1:0] spec_id,
  output logic            ckpt_full,
  input  logic            res_valid,
  input  logic [ID_W-1:0] res_id,
  input  logic [31:0]     res_pc,
  input  logic            res_taken,
  input  logic            res_mispred,
  input  logic            flush,
  output logic            order_err
);

  localparam int unsigned PHT_N    = 2 ** IDX_W;
  localparam int unsigned CTR_MAX  = (2 ** CTR_W) - 1;
  localparam int unsigned INIT_CTR = 2 ** (CTR_W - 1);

  state_e state;
  state_e state_next;

  logic [IDX_W-1:0]   sweep_cnt;
  logic [GHR_LEN-1:0] spec_ghr;
  logic [GHR_LEN-1:0] arch_ghr;
  logic [GHR_LEN-1:0] spec_ghr_next;
  logic [GHR_LEN-1:0] arch_ghr_next;
  logic [GHR_LEN-1:0] ckpt_ghr;
  logic [CTR_W-1:0]   pht [PHT_N];

  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [CTR_W-1:0] upd_ctr;
  logic [CTR_W-1:0] wr_data;
  logic             wr_en;
  logic             q_push;
  logic             q_pop;
  logic             q_clear;
  logic             q_full;
  logic             q_empty;
  logic             err_set;
  logic [ID_W-1:0]  head_id;
  logic [ID_W-1:0]  tail_id;

  bp_ckpt_queue #(
    .W    (GHR_LEN),
    .DEPTH(CKPT_DEPTH),
    .ID_W (ID_W)
  ) u_ckpt_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_data(spec_ghr),
    .pop      (q_pop),
    .clear    (q_clear),
    .head_data(ckpt_ghr),
    .head_id  (head_id),
    .tail_id  (tail_id),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign f_idx        = IDX_W'(pht_idx(pc_f, 32'(spec_ghr)));
  assign upd_idx      = IDX_W'(pht_idx(res_pc, 32'(ckpt_ghr)));
  assign upd_ctr      = CTR_W'(ctr_next(32'(pht[upd_idx]), res_taken, 32'(CTR_MAX)));
  assign pred_taken_f = ready & pht[f_idx][CTR_W-1];
  assign spec_id      = tail_id;
  assign ckpt_full    = q_full;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep_cnt == IDX_W'(PHT_N - 1)) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Sweep writes in INIT; in RUN a resolve drives the PHT, queue and histories.
  always_comb begin
    wr_en         = 1'b0;
    wr_idx        = sweep_cnt;
    wr_data       = CTR_W'(INIT_CTR);
    q_push        = 1'b0;
    q_pop         = 1'b0;
    q_clear       = 1'b0;
    err_set       = 1'b0;
    arch_ghr_next = arch_ghr;
    spec_ghr_next = spec_ghr;
    case (state)
      INIT: wr_en = 1'b1;
      RUN: begin
        wr_en   = res_valid;
        wr_idx  = upd_idx;
        wr_data = upd_ctr;
        q_pop   = res_valid & ~q_empty;
        q_clear = flush | (res_valid & res_mispred);
        q_push  = spec_valid & ~q_full & ~q_clear;
        err_set = res_valid & (q_empty | (res_id != head_id));
        if (res_valid) arch_ghr_next = GHR_LEN'({arch_ghr, res_taken});
        if (flush)                          spec_ghr_next = arch_ghr_next;
        else if (res_valid && res_mispred)  spec_ghr_next = GHR_LEN'({ckpt_ghr, res_taken});
        else if (q_push)                    spec_ghr_next = GHR_LEN'({spec_ghr, spec_taken});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt <= '0;
      spec_ghr  <= '0;
      arch_ghr  <= '0;
      ready     <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (state == INIT) sweep_cnt <= sweep_cnt + IDX_W'(1);
      spec_ghr <= spec_ghr_next;
      arch_ghr <= arch_ghr_next;
      ready    <= (state_next == RUN);
      if (err_set) order_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) pht[wr_idx] <= wr_data;
  end

endmodule
